// File: rtl/branch_ex_pkg.sv
// Shared definitions for the branch execution unit: opcode encodings,
// idle values for tag/data buses, FSM state type and small helpers.
package branch_ex_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned MAX_W = 64;

  localparam logic [OP_W-1:0] OP_NOP  = 6'd0;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'd1;
  localparam logic [OP_W-1:0] OP_BNE  = 6'd2;
  localparam logic [OP_W-1:0] OP_BLT  = 6'd3;
  localparam logic [OP_W-1:0] OP_BGE  = 6'd4;
  localparam logic [OP_W-1:0] OP_BLTU = 6'd5;
  localparam logic [OP_W-1:0] OP_BGEU = 6'd6;
  localparam logic [OP_W-1:0] OP_JAL  = 6'd7;
  localparam logic [OP_W-1:0] OP_JALR = 6'd8;

  // Idle bus values; truncated to the instance width at the point of use.
  localparam logic [MAX_W-1:0] TAG_FREE_ALL  = '1;
  localparam logic [MAX_W-1:0] DATA_FREE_ALL = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_HOLD,
    ST_FLUSH
  } state_t;

  // Jumps that write a link register.
  function automatic logic is_link(input logic [OP_W-1:0] op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/branch_ex_if.sv
// Issue / CDB / redirect bundle between the branch reservation station side
// (master) and the branch execution unit (slave).
interface branch_ex_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
);
  import branch_ex_pkg::*;

  logic              BranchWorkEn;
  logic [DATA_W-1:0] operandO;
  logic [DATA_W-1:0] operandT;
  logic [DATA_W-1:0] imm;
  logic [OP_W-1:0]   opCode;
  logic [DATA_W-1:0] PC;
  logic              predTaken;
  logic [TAG_W-1:0]  rdTag;
  logic              BranchReady;
  logic              enBranchWrt;
  logic [TAG_W-1:0]  BranchTag;
  logic [DATA_W-1:0] BranchData;
  logic              cdbGrant;
  logic              jumpEn;
  logic [DATA_W-1:0] jumpAddr;

  modport master (
    output BranchWorkEn, operandO, operandT, imm, opCode, PC, predTaken,
           rdTag, cdbGrant,
    input  BranchReady, enBranchWrt, BranchTag, BranchData, jumpEn, jumpAddr
  );

  modport slave (
    input  BranchWorkEn, operandO, operandT, imm, opCode, PC, predTaken,
           rdTag, cdbGrant,
    output BranchReady, enBranchWrt, BranchTag, BranchData, jumpEn, jumpAddr
  );

endinterface

// File: rtl/branch_cmp.sv
// Combinational branch condition and target computation.
module branch_cmp
  import branch_ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] pc,
  output logic              taken_c,
  output logic [DATA_W-1:0] target_c,
  output logic [DATA_W-1:0] link_c
);

  logic [DATA_W-1:0] pc_rel;
  logic [DATA_W-1:0] reg_rel;

  // Condition evaluation; unknown opcodes resolve as not taken.
  always_comb begin
    taken_c = 1'b0;
    case (op)
      OP_BEQ:  taken_c = (rs1 == rs2);
      OP_BNE:  taken_c = (rs1 != rs2);
      OP_BLT:  taken_c = ($signed(rs1) <  $signed(rs2));
      OP_BGE:  taken_c = ($signed(rs1) >= $signed(rs2));
      OP_BLTU: taken_c = (rs1 <  rs2);
      OP_BGEU: taken_c = (rs1 >= rs2);
      OP_JAL:  taken_c = 1'b1;
      OP_JALR: taken_c = 1'b1;
      default: taken_c = 1'b0;
    endcase
  end

  // Targets wrap modulo 2^DATA_W; JALR target is halfword aligned.
  always_comb begin
    pc_rel   = pc + imm;
    reg_rel  = rs1 + imm;
    link_c   = pc + DATA_W'(4);
    target_c = (op == OP_JALR) ? {reg_rel[DATA_W-1:1], 1'b0} : pc_rel;
  end

endmodule

// File: rtl/branch_ex.sv
// Branch execution unit: resolves one branch/jump at a time, pulses a fetch
// redirect on mispredict or JALR, writes JAL/JALR link values to the CDB and
// blocks issue for FLUSH_CYC cycles after a redirect.
// Optional feature macro: BRANCH_STAT_EN adds statBranches/statMispredicts.
module branch_ex
  import branch_ex_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  branch_ex_if.slave  bus
`ifdef BRANCH_STAT_EN
  ,
  output logic [31:0] statBranches,
  output logic [31:0] statMispredicts
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [TAG_W-1:0]  TAG_FREE  = TAG_W'(TAG_FREE_ALL);
  localparam logic [DATA_W-1:0] DATA_FREE = DATA_W'(DATA_FREE_ALL);

  state_t            state;
  logic [CNT_W-1:0]  flush_cnt;
  logic              redirect_q;

  logic              taken_c;
  logic [DATA_W-1:0] target_c;
  logic [DATA_W-1:0] link_c;
  logic              issue_c;
  logic              redir_c;
  logic              wr_c;

  branch_cmp #(.DATA_W(DATA_W)) u_cmp (
    .op       (bus.opCode),
    .rs1      (bus.operandO),
    .rs2      (bus.operandT),
    .imm      (bus.imm),
    .pc       (bus.PC),
    .taken_c  (taken_c),
    .target_c (target_c),
    .link_c   (link_c)
  );

  // Issue qualification and resolution of the instruction being accepted.
  always_comb begin
    issue_c = bus.BranchWorkEn && bus.BranchReady && (bus.opCode != OP_NOP);
    redir_c = (taken_c != bus.predTaken) || (bus.opCode == OP_JALR);
    wr_c    = is_link(bus.opCode) && (bus.rdTag != TAG_FREE);
  end

  // FSM with registered outputs; results are registered on issue so they are
  // presented during the EXEC cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= ST_IDLE;
      flush_cnt       <= '0;
      redirect_q      <= 1'b0;
      bus.BranchReady <= 1'b1;
      bus.jumpEn      <= 1'b0;
      bus.jumpAddr    <= DATA_FREE;
      bus.enBranchWrt <= 1'b0;
      bus.BranchTag   <= TAG_FREE;
      bus.BranchData  <= DATA_FREE;
    end else begin
      bus.jumpEn   <= 1'b0;
      bus.jumpAddr <= DATA_FREE;
      case (state)
        ST_IDLE: begin
          if (issue_c) begin
            state           <= ST_EXEC;
            bus.BranchReady <= 1'b0;
            redirect_q      <= redir_c;
            bus.jumpEn      <= redir_c;
            if (redir_c) begin
              bus.jumpAddr <= taken_c ? target_c : link_c;
            end
            if (wr_c) begin
              bus.enBranchWrt <= 1'b1;
              bus.BranchTag   <= bus.rdTag;
              bus.BranchData  <= link_c;
            end
          end
        end
        ST_EXEC, ST_HOLD: begin
          if (bus.enBranchWrt && !bus.cdbGrant) begin
            state <= ST_HOLD;
          end else begin
            bus.enBranchWrt <= 1'b0;
            bus.BranchTag   <= TAG_FREE;
            bus.BranchData  <= DATA_FREE;
            redirect_q      <= 1'b0;
            if (redirect_q) begin
              state     <= ST_FLUSH;
              flush_cnt <= CNT_W'(FLUSH_CYC - 1);
            end else begin
              state           <= ST_IDLE;
              bus.BranchReady <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == '0) begin
            state           <= ST_IDLE;
            bus.BranchReady <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - CNT_W'(1);
          end
        end
        default: begin
          state           <= ST_IDLE;
          bus.BranchReady <= 1'b1;
        end
      endcase
    end
  end

`ifdef BRANCH_STAT_EN
  // Resolved-branch and redirect counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      statBranches    <= '0;
      statMispredicts <= '0;
    end else begin
      if (state == ST_EXEC) begin
        statBranches <= statBranches + 32'd1;
      end
      if (bus.jumpEn) begin
        statMispredicts <= statMispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/branch_ex.md
BRANCH_EX -- requirements
Module: branch_ex

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/address width.
REQ-002 SHALL have parameter TAG_W, default 4, rename-tag width; tagFree = all ones.
REQ-003 SHALL have parameter FLUSH_CYC, default 2, cycles of issue block after a redirect, range 1..15.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port BranchWorkEn  input  1  issue valid from the branch RS.
REQ-007 SHALL have ports operandO, operandT, imm  input  DATA_W each  rs1 value, rs2 value, immediate.
REQ-008 SHALL have port opCode  input  OP_W (6)  BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR/NOP.
REQ-009 SHALL have ports PC  input  DATA_W  instruction address; predTaken  input  1  fetch prediction.
REQ-010 SHALL have port rdTag  input  TAG_W  link destination tag, tagFree if none.
REQ-011 SHALL have port BranchReady  output  1  may accept an issue this cycle.
REQ-012 SHALL have ports enBranchWrt  output  1, BranchTag  output  TAG_W, BranchData  output  DATA_W  CDB link write.
REQ-013 SHALL have port cdbGrant  input  1  CDB accepted the write this cycle.
REQ-014 SHALL have ports jumpEn  output  1, jumpAddr  output  DATA_W  fetch redirect pulse.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, HOLD, FLUSH; BranchReady = 1 only in IDLE.
REQ-016 SHALL capture inputs and enter EXEC on a rising edge with BranchWorkEn=1, BranchReady=1, opCode!=NOP; NOP issues ignored, remain IDLE.
REQ-017 SHALL evaluate in EXEC: signed compares for BLT/BGE, unsigned for BLTU/BGEU, equality for BEQ/BNE; JAL/JALR always taken.
REQ-018 SHALL form target PC+imm (branches, JAL), (operandO+imm) with bit0 cleared (JALR), all modulo 2^DATA_W; fallthrough PC+4.
REQ-019 SHALL pulse jumpEn for exactly the EXEC cycle when taken!=predTaken or opCode=JALR; jumpAddr = target if taken else fallthrough.
REQ-020 SHALL assert enBranchWrt from EXEC for JAL/JALR with rdTag!=tagFree, BranchData=PC+4, BranchTag=rdTag, held stable until cdbGrant=1.
REQ-021 SHALL transition EXEC->HOLD if write not granted in EXEC; EXEC/HOLD->FLUSH on grant (or no write) if redirected; else ->IDLE; latency issue to jumpEn = 1 cycle.
REQ-022 SHALL remain in FLUSH exactly FLUSH_CYC cycles, counter down to 0, then IDLE.
REQ-023 SHALL drive outputs idle (0, tagFree) whenever not asserting them.

Reset
REQ-024 SHALL, on any rising edge with rst=0 in any state, go to IDLE, clear counter, drop pending write/redirect; outputs 0 except BranchTag=tagFree and BranchReady=1 after release.

Configuration
REQ-025 SHALL, with BRANCH_STAT_EN defined, add 32-bit outputs statBranches and statMispredicts, incrementing per EXEC/per jumpEn, wrapping, cleared by reset; without it, no ports or counters.

Structure
REQ-026 SHALL take opcode encodings, tagFree, dataFree from the shared defines package.
REQ-027 SHALL place compare/target logic in combinational sub-module branch_cmp.

Verification
REQ-028 BEQ 5,5, PC=0x100, imm=0x20, predTaken=0 -> next cycle jumpEn=1, jumpAddr=0x120, then 2 FLUSH cycles, BranchReady=0.
REQ-029 BLT -1,1 predTaken=1; BLTU 0xFFFFFFFF,1 predTaken=0 -> no jumpEn either; back-to-back issue accepted.
REQ-030 JAL PC=0x40, rdTag=3, cdbGrant low 3 cycles -> enBranchWrt held with 0x44/tag 3, then FLUSH, then IDLE.
REQ-031 JALR operandO=0x201, imm=0 -> jumpAddr=0x200, jumpEn=1.
REQ-032 rst=0 during HOLD -> next edge IDLE, enBranchWrt=0, no later jumpEn.
REQ-033 BRANCH_STAT_EN: 3 branches, 1 mispredict -> statBranches=3, statMispredicts=1.
